// File: rtl/kernel_d_stream_ctrl_if.sv
// Stream bundle between the controller, its upstream source, the kernel and the downstream sink.
// The slave modport is the controller's view; master is the surrounding environment.
interface kernel_d_stream_ctrl_if #(
    parameter int STREAMW = 32
);
    logic               src_valid;
    logic               src_ready;
    logic [STREAMW-1:0] src_data;
    logic               k_ivalid;
    logic               k_iready;
    logic [STREAMW-1:0] k_din;
    logic               k_ovalid;
    logic               k_oready;
    logic [STREAMW-1:0] k_dout;
    logic               snk_valid;
    logic               snk_ready;
    logic [STREAMW-1:0] snk_data;

    modport slave (
        input  src_valid, src_data, k_iready, k_ovalid, k_dout, snk_ready,
        output src_ready, k_ivalid, k_din, k_oready, snk_valid, snk_data
    );

    modport master (
        output src_valid, src_data, k_iready, k_ovalid, k_dout, snk_ready,
        input  src_ready, k_ivalid, k_din, k_oready, snk_valid, snk_data
    );
endinterface

// File: rtl/kernel_d_stream_ctrl.sv
// Run controller that feeds a fixed number of items through an opaque-latency kernel,
// bounding the items in flight and pulsing done once every issued item has retired.
module kernel_d_stream_ctrl #(
    parameter int STREAMW = 32,
    parameter int CNTW    = 16,
    parameter int MAXINFL = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] nitems,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] icount,
    output logic [CNTW-1:0] ocount,
    kernel_d_stream_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [CNTW-1:0] MAX_INFL = CNTW'(MAXINFL);
    localparam logic [CNTW-1:0] ONE      = CNTW'(1);

    state_t             state;
    state_t             state_next;
    logic [CNTW-1:0]    nlat;
    logic [CNTW-1:0]    inflight;
    logic               issue_en;
    logic               ret_en;
    logic               issue_beat;
    logic               retire_beat;
    logic               issue_last;
    logic               retire_last;
    logic               accept_start;
    logic [STREAMW-1:0] in_word;
    logic [STREAMW-1:0] out_word;

    assign inflight     = icount - ocount;
    assign issue_en     = (state == RUN) && (icount < nlat) && (inflight < MAX_INFL);
    assign ret_en       = (state == RUN) || (state == DRAIN);
    assign accept_start = (state == IDLE) && start;

    // Data passes straight through; only the handshakes are gated by the run state.
    assign in_word      = io.src_data;
    assign out_word     = io.k_dout;
    assign io.k_din     = in_word;
    assign io.snk_data  = out_word;
    assign io.k_ivalid  = io.src_valid & issue_en;
    assign io.src_ready = io.k_iready & issue_en;
    assign io.k_oready  = io.snk_ready & ret_en;
    assign io.snk_valid = io.k_ovalid & ret_en;

    assign issue_beat   = io.src_valid & io.src_ready;
    assign retire_beat  = io.k_ovalid & io.k_oready;
    assign issue_last   = issue_beat && ((icount + ONE) == nlat);
    assign retire_last  = retire_beat && ((ocount + ONE) == nlat);

    assign busy = ret_en;
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-latency kernel can issue and retire the final item together, so retire wins.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (nitems != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (retire_last) begin
                    state_next = DONE;
                end else if (issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (retire_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nlat   <= '0;
            icount <= '0;
            ocount <= '0;
        end else if (accept_start) begin
            nlat   <= nitems;
            icount <= '0;
            ocount <= '0;
        end else begin
            if (issue_beat) begin
                icount <= icount + ONE;
            end
            if (retire_beat) begin
                ocount <= ocount + ONE;
            end
        end
    end
endmodule

// File: doc/kernel_d_stream_ctrl.md
KERNEL_D_STREAM_CTRL -- requirements
Module: kernel_d_stream_ctrl

Interface
REQ-001 SHALL have parameters: STREAMW, default 32, stream data width; CNTW, default 16, item-count width; MAXINFL, default 8, maximum items in flight inside the kernel (1..2^CNTW-1).
REQ-002 SHALL have ports, one per line: name direction width meaning.
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  launch request, sampled in IDLE only
- nitems  in  CNTW  items to process, latched on accepted start
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle completion pulse
- src_valid  in  1  upstream data valid
- src_ready  out  1  upstream accept
- src_data  in  STREAMW  upstream data
- k_ivalid  out  1  to kernel ivalid
- k_iready  in  1  from kernel iready
- k_din  out  STREAMW  to kernel input stream
- k_ovalid  in  1  from kernel ovalid
- k_oready  out  1  to kernel oready
- k_dout  in  STREAMW  from kernel output stream
- snk_valid  out  1  downstream valid
- snk_ready  in  1  downstream ready
- snk_data  out  STREAMW  downstream data
- icount  out  CNTW  items issued to kernel this run
- ocount  out  CNTW  items retired from kernel this run

Function
REQ-003 SHALL implement FSM states IDLE, RUN, DRAIN, DONE; reset state IDLE.
REQ-004 IDLE: start=1 and nitems!=0 -> RUN next cycle; latch nitems into nlat; clear icount, ocount.
REQ-005 IDLE: start=1 and nitems==0 -> DONE directly; counters cleared; no kernel traffic.
REQ-006 start SHALL be ignored in RUN, DRAIN, DONE; nlat SHALL not change until the next accepted start.
REQ-007 issue_en = (state==RUN) & (icount<nlat) & (inflight<MAXINFL), where inflight = icount-ocount, computed CNTW wide.
REQ-008 k_ivalid = src_valid & issue_en; src_ready = k_iready & issue_en; k_din = src_data, combinational.
REQ-009 issue beat = src_valid & src_ready; icount SHALL increment by 1 per issue beat.
REQ-010 ret_en = (state==RUN or DRAIN); k_oready = snk_ready & ret_en; snk_valid = k_ovalid & ret_en; snk_data = k_dout.
REQ-011 retire beat = k_ovalid & k_oready; ocount SHALL increment by 1 per retire beat.
REQ-012 issue and retire beats in the same cycle SHALL both count; inflight is unchanged.
REQ-013 RUN -> DRAIN in the cycle after the issue beat that makes icount==nlat.
REQ-014 RUN or DRAIN -> DONE in the cycle after the retire beat that makes ocount==nlat; if that retire occurs while still in RUN with icount==nlat, go directly to DONE.
REQ-015 DONE SHALL last exactly one cycle, drive done=1, then return to IDLE; icount/ocount SHALL hold final values until the next accepted start.
REQ-016 inflight SHALL never exceed MAXINFL; icount and ocount SHALL never exceed nlat; no wrap-around possible.
REQ-017 In IDLE and DONE, src_ready, k_ivalid, k_oready and snk_valid SHALL be 0; a stray kernel output stalls rather than being lost.
REQ-018 Controller adds zero cycles of data latency; kernel latency is opaque and handled only via inflight.

Reset
REQ-019 rst=1 SHALL immediately force: state IDLE, icount=0, ocount=0, nlat=0, busy=0, done=0, all handshake outputs 0.
REQ-020 rst mid-run SHALL abandon the run without a done pulse; the kernel SHALL share the same rst so no items stay in flight.

Verification
REQ-021 nitems=5, src always valid, kernel iready=1, latency 3, snk_ready=1 -> 5 issues, 5 retires, single done pulse, icount=ocount=5.
REQ-022 nitems=20, MAXINFL=2, kernel latency 6 -> k_ivalid drops whenever inflight=2, never 3; run completes with ocount=20.
REQ-023 nitems=0 start -> DONE next cycle, done pulse, no src_ready asserted.
REQ-024 nitems=10, random src_valid/k_iready/snk_ready toggling -> snk stream equals expected 10 items in order, no duplicates or losses.
REQ-025 start pulses during RUN with nitems=99 -> ignored, nlat stays at original value.
REQ-026 rst asserted after 3 of 8 issues -> outputs zero asynchronously, no done; new start with nitems=4 completes normally.
